// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the nibble-serial multiply sequencer.
// Imported by mul_seq_controller and mul4x4_array.
package mul_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Number of nibble-pair passes for an opw x opw multiply.
    function automatic int npasses(input int opw);
        return (opw / NIB_W) * (opw / NIB_W);
    endfunction

    // Left shift applied to the partial product of nibbles i and j.
    function automatic int shamt(input int i, input int j);
        return NIB_W * (i + j);
    endfunction

endpackage

// File: rtl/mul_seq_controller_mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier: AND-gate partial products
// reduced row by row through ripple full adders.
module mul4x4_array
    import mul_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    logic [NIB_W-1:0] pp [NIB_W];

    always_comb begin
        for (int r = 0; r < NIB_W; r++) begin
            pp[r] = a & {NIB_W{b[r]}};
        end
    end

    // hi carries the upper bits of the running sum into the next row.
    always_comb begin
        logic [NIB_W-1:0] hi;
        logic [NIB_W-1:0] s;
        logic             c;
        logic [1:0]       r_fa;
        p    = '0;
        s    = '0;
        c    = 1'b0;
        r_fa = '0;
        p[0] = pp[0][0];
        hi   = {1'b0, pp[0][NIB_W-1:1]};
        for (int r = 1; r < NIB_W; r++) begin
            c = 1'b0;
            for (int k = 0; k < NIB_W; k++) begin
                r_fa = fa(pp[r][k], hi[k], c);
                s[k] = r_fa[0];
                c    = r_fa[1];
            end
            p[r] = s[0];
            hi   = {c, s[NIB_W-1:1]};
        end
        p[2*NIB_W-1:NIB_W] = hi;
    end

endmodule

// File: rtl/mul_seq_controller.sv
// Sequencer for an OPW x OPW unsigned multiply over one shared 4x4 array.
// Optional MUL_SEQ_ZERO_SKIP_EN: zero operands finish after a single cycle.
//
// state  | meaning
// S_IDLE | ready for a request, in_ready high
// S_MUL  | one nibble pair accumulated per cycle
// S_DONE | result presented, waiting for out_ready
module mul_seq_controller
    import mul_seq_pkg::*;
#(
    parameter int OPW   = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     in_a,
    input  logic [OPW-1:0]     in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*OPW-1:0]   out_prod,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int NNIB = OPW / NIB_W;
    localparam int NP   = npasses(OPW);
    localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int PCW  = (NP > 1) ? $clog2(NP) : 1;
    localparam int PW   = 2 * OPW;

    localparam logic [IW-1:0]  LAST_NIB  = IW'(NNIB - 1);
    localparam logic [PCW-1:0] PASS_LOAD = PCW'(NP - 1);

    state_t             state;
    logic [OPW-1:0]     a_q;
    logic [OPW-1:0]     b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [PW-1:0]      acc;
    logic [IW-1:0]      i_q;
    logic [IW-1:0]      j_q;
    logic [PCW-1:0]     pass_left;

    logic [NIB_W-1:0]   a_nibs [NNIB];
    logic [NIB_W-1:0]   b_nibs [NNIB];
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [2*NIB_W-1:0] pp;
    logic [PW-1:0]      acc_nxt;
    logic               last_pass;

    for (genvar k = 0; k < NNIB; k++) begin : g_nib
        assign a_nibs[k] = a_q[k*NIB_W +: NIB_W];
        assign b_nibs[k] = b_q[k*NIB_W +: NIB_W];
    end

    assign a_nib = a_nibs[i_q];
    assign b_nib = b_nibs[j_q];

    mul4x4_array u_array (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    assign acc_nxt   = acc + (PW'(pp) << shamt(int'(i_q), int'(j_q)));
    assign last_pass = (pass_left == '0);
    assign in_ready  = (state == S_IDLE) & ~rst;

`ifdef MUL_SEQ_ZERO_SKIP_EN
    logic zero_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            acc       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            pass_left <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_tag   <= '0;
            busy      <= 1'b0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        tag_q     <= in_tag;
                        acc       <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        pass_left <= PASS_LOAD;
                        busy      <= 1'b1;
                        state     <= S_MUL;
`ifdef MUL_SEQ_ZERO_SKIP_EN
                        zero_q    <= (in_a == '0) || (in_b == '0);
`endif
                    end
                end
                S_MUL: begin
`ifdef MUL_SEQ_ZERO_SKIP_EN
                    if (zero_q) begin
                        out_prod  <= '0;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else
`endif
                    begin
                        acc       <= acc_nxt;
                        pass_left <= pass_left - 1'b1;
                        if (i_q == LAST_NIB) begin
                            i_q <= '0;
                            j_q <= j_q + 1'b1;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                        if (last_pass) begin
                            out_prod  <= acc_nxt;
                            out_tag   <= tag_q;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_controller.sv
// Self-checking bench for mul_seq_controller: directed cases, reset and
// backpressure boundaries, then a randomized back-to-back stream.
module tb_mul_seq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [3:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mul_seq_controller #(.OPW(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_SEQ_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 1;
`endif
        return (8 / 4) * (8 / 4);
    endfunction

    function automatic logic [31:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        return 32'(a) * 32'(b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result and check it; leaves DONE pending.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        int lat;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_a   = ~a;
        in_b   = 8'h5A;
        in_tag = ~t;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("mul_in_ready", 32'(in_ready), 32'd0);
            check("mul_busy", 32'(busy), 32'd1);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_latency(a, b)));
        check("prod", 32'(out_prod), ref_prod(a, b));
        check("tag", 32'(out_tag), 32'(t));
        check("done_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] held_prod;
        logic [3:0]  held_tag;
        logic [19:0] exp_q [$];
        logic [19:0] front;
        int          sent;
        int          got;
        int          cyc;
        logic        hs_in;
        logic        hs_out;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prod", 32'(out_prod), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // out_ready with nothing pending must do nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_ready_out_valid", 32'(out_valid), 32'd0);
        check("idle_ready_in_ready", 32'(in_ready), 32'd1);

        run_op(8'h12, 8'h34, 4'd3);
        check("const_12x34", 32'(out_prod), 32'h03A8);
        release_result();

        run_op(8'hFF, 8'hFF, 4'd5);
        check("const_ffxff", 32'(out_prod), 32'hFE01);
        release_result();

        run_op(8'hC8, 8'h96, 4'd9);
        check("const_c8x96", 32'(out_prod), 32'h7530);
        held_prod = out_prod;
        held_tag  = out_tag;
        in_valid  = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_prod_stable", 32'(out_prod), 32'(held_prod));
            check("bp_tag_stable", 32'(out_tag), 32'(held_tag));
            check("bp_no_accept", 32'(in_ready), 32'd0);
        end
        release_result();

        // Reset during the second pass drops the operation
        in_a     = 8'h55;
        in_b     = 8'h66;
        in_tag   = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_prod", 32'(out_prod), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end

        run_op(8'h0A, 8'h0B, 4'd1);
        check("const_0ax0b", 32'(out_prod), 32'h006E);
        release_result();

        run_op(8'h00, 8'h5A, 4'd2);
        release_result();

        // Reset wins over a simultaneous result handshake
        run_op(8'h21, 8'h43, 4'd4);
        out_ready = 1'b1;
        rst       = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rst_hs_out_valid", 32'(out_valid), 32'd0);
        check("rst_hs_out_prod", 32'(out_prod), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_hs_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back randomized stream
        sent   = 0;
        got    = 0;
        cyc    = 0;
        in_a   = 8'($urandom_range(0, 255));
        in_b   = 8'($urandom_range(0, 255));
        in_tag = 4'd0;
        while (got < 20 && cyc < 2000) begin
            in_valid  = (sent < 20);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected", 32'd1, 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    check("rnd_prod", 32'(out_prod), 32'(front[15:0]));
                    check("rnd_tag", 32'(out_tag), 32'(front[19:16]));
                end
                got++;
            end
            tick();
            if (hs_in) begin
                exp_q.push_back({in_tag, 16'(ref_prod(in_a, in_b))});
                sent++;
                case ($urandom_range(0, 5))
                    0:       in_a = 8'h00;
                    1:       in_a = 8'hFF;
                    default: in_a = 8'($urandom_range(0, 255));
                endcase
                case ($urandom_range(0, 5))
                    0:       in_b = 8'h00;
                    1:       in_b = 8'hFF;
                    default: in_b = 8'($urandom_range(0, 255));
                endcase
                in_tag = in_tag + 4'd1;
            end
            cyc++;
        end
        check("rnd_all_received", 32'(got), 32'd20);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
